fetch_seq: RTL and testbench

Multicycle instruction sequencer for the RV32 core. It owns the program counter and fetches each instruction from instruction memory through a request/ready handshake. It presents the instruction to the datapath and waits for completion. It then applies the branch decision (`NextPCSrc` from the branch unit, target from the ALU) to select the next PC. It also detects misaligned targets and fetch timeouts, and counts retired instructions.

---
 rtl/fetch_seq.sv | 149 ++++++++++++++
 tb/tb_fetch_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: multicycle RV32 instruction sequencer.
// It owns the PC, fetches each instruction over a req/ready handshake and
// holds it while the datapath executes. When the instruction completes it
// steers the PC to either pc+4 or the branch target. Misaligned next-PCs
// and unanswered fetches end in a sticky trap state that only reset clears.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        NextPCSrc,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam logic [31:0] TIMEOUT_W = TIMEOUT[31:0];
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;

  logic        fetch_hs;
  logic        fetch_miss;
  logic        timeout_hit;
  logic [31:0] next_pc;

  // Address path and Moore-style status outputs straight from the registers.
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instret     = instret_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign instr_valid = (state_q == S_EXEC);
  // A stalled FETCH cycle withdraws the request, so ready is ignored then.
  assign imem_req    = (state_q == S_FETCH) && !stall;

  assign fetch_hs    = imem_req && imem_ready;
  assign fetch_miss  = imem_req && !imem_ready;
  // The N-th unanswered request cycle is the one where the count is N-1.
  assign timeout_hit = (TIMEOUT_W != 32'd0) && fetch_miss &&
                       ((to_cnt_q + 32'd1) == TIMEOUT_W);
  assign next_pc     = NextPCSrc ? target : pc_plus4;

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    to_cnt_d  = to_cnt_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    case (state_q)
      S_IDLE: begin
        if (!stall) begin
          state_d  = S_FETCH;
          to_cnt_d = 32'd0;
        end
      end
      S_FETCH: begin
        if (fetch_hs) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end else if (fetch_miss) begin
          to_cnt_d = to_cnt_q + 32'd1;
          if (timeout_hit) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          if (next_pc[1:0] != 2'b00) begin
            // Faulting instruction is not retired and pc keeps pointing at it.
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
            to_cnt_d  = 32'd0;
            state_d   = S_FETCH;
          end
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All sequencer state, with asynchronous reset to the architectural reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= 32'd0;
      to_cnt_q  <= 32'd0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      to_cnt_q  <= to_cnt_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed steps followed by a randomized phase for fetch_seq,
// checked every cycle against a transaction-level reference model.
module tb_fetch_seq;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        NextPCSrc;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  fetch_seq #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .NextPCSrc  (NextPCSrc),
    .target     (target),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: what the sequencer is doing, in transaction terms.
  bit          m_fetching;
  bit          m_executing;
  bit          m_trapped;
  int          m_misses;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_instret;
  logic [1:0]  m_cause;

  function automatic void model_reset();
    m_fetching  = 1'b0;
    m_executing = 1'b0;
    m_trapped   = 1'b0;
    m_misses    = 0;
    m_pc        = RPC;
    m_instr     = 32'h0000_0013;
    m_instret   = 32'd0;
    m_cause     = 2'b00;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_step();
    logic [31:0] nxt;
    if (m_trapped) begin
      // nothing leaves the trap except reset
    end else if (m_executing) begin
      if (exec_done) begin
        nxt = NextPCSrc ? target : m_pc + 32'd4;
        if (nxt % 4 != 0) begin
          m_executing = 1'b0;
          m_trapped   = 1'b1;
          m_cause     = 2'b01;
        end else begin
          m_pc        = nxt;
          m_instret   = m_instret + 32'd1;
          m_executing = 1'b0;
          m_fetching  = 1'b1;
          m_misses    = 0;
        end
      end
    end else if (m_fetching) begin
      if (!stall) begin
        if (imem_ready) begin
          m_instr     = imem_rdata;
          m_fetching  = 1'b0;
          m_executing = 1'b1;
        end else begin
          m_misses = m_misses + 1;
          if (TO != 0 && m_misses == int'(TO)) begin
            m_fetching = 1'b0;
            m_trapped  = 1'b1;
            m_cause    = 2'b10;
          end
        end
      end
    end else if (!stall) begin
      m_fetching = 1'b1;
      m_misses   = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req",    {31'd0, imem_req},    {31'd0, m_fetching && !stall});
    chk("imem_addr",   imem_addr,            m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_executing});
    chk("pc",          pc,                   m_pc);
    chk("pc_plus4",    pc_plus4,             m_pc + 32'd4);
    chk("instr",       instr,                m_instr);
    chk("trap",        {31'd0, trap},        {31'd0, m_trapped});
    chk("trap_cause",  {30'd0, trap_cause},  {30'd0, m_cause});
    chk("instret",     instret,              m_instret);
    chk("req_valid_excl", {31'd0, imem_req & instr_valid}, 32'd0);
  endtask

  task automatic drive(input logic s, input logic r, input logic ed,
                       input logic nps, input logic [31:0] tgt);
    stall      = s;
    imem_ready = r;
    exec_done  = ed;
    NextPCSrc  = nps;
    target     = tgt;
    imem_rdata = $urandom;
  endtask

  // One clock: check current outputs, take the edge, step the model.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Pulse rst_n low between edges; outputs must return to reset values at once.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_instr_nop", instr, 32'h0000_0013);
    chk("reset_req", {31'd0, imem_req}, 32'd0);

    // Reset release with ready tied high: request in cycle 2, valid in cycle 3.
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    cycle();
    chk("c2_req", {31'd0, imem_req}, 32'd1);
    chk("c2_addr", imem_addr, 32'h0);
    cycle();
    chk("c3_valid", {31'd0, instr_valid}, 32'd1);
    repeat (5) cycle();
    chk("seq_pc", pc, 32'hC);
    chk("seq_instret", instret, 32'd3);

    // Async reset in the middle of EXEC.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle();
    chk("exec_before_rst", {31'd0, instr_valid}, 32'd1);
    async_reset();
    chk("rst_exec_pc", pc, RPC);
    chk("rst_exec_instret", instret, 32'd0);

    // Resume from RESET_PC; at pc=8 a not-taken branch goes to C.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    repeat (5) cycle();
    chk("resume_pc8", pc, 32'h8);
    cycle();
    cycle();
    chk("nt_addr", imem_addr, 32'hC);

    // Async reset in the middle of FETCH, then a taken branch at pc=8.
    async_reset();
    chk("rst_fetch_req", {31'd0, imem_req}, 32'd0);
    chk("rst_fetch_pc", pc, RPC);
    repeat (5) cycle();
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    cycle();
    chk("br_addr", imem_addr, 32'h40);
    chk("br_instret", instret, 32'd3);

    // PC wrap: jump to FFFF_FFFC, then fall through to 0.
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle();
    cycle();
    chk("wrap_next_pc", pc, 32'h0);
    chk("wrap_instret", instret, 32'd5);

    // Misaligned target traps with pc and instret frozen.
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h42);
    cycle();
    chk("mis_trap", {31'd0, trap}, 32'd1);
    chk("mis_cause", {30'd0, trap_cause}, 32'd1);
    chk("mis_pc", pc, 32'h0);
    chk("mis_instret", instret, 32'd5);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("trap_no_req", {31'd0, imem_req}, 32'd0);
    end

    // Fetch timeout with two stalled cycles in the middle of the wait.
    async_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    cycle();
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk("to_pending", {31'd0, trap}, 32'd0);
    cycle();
    chk("to_trap", {31'd0, trap}, 32'd1);
    chk("to_cause", {30'd0, trap_cause}, 32'd2);
    chk("to_pc", pc, 32'h0);

    // Randomized traffic against the model, with occasional resets.
    async_reset();
    for (int i = 0; i < 800; i++) begin
      t = $urandom;
      if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, t);
      cycle();
      if (m_trapped && $urandom_range(0, 5) == 0) async_reset();
      else if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
